// File: rtl/irrigation_zone_controller_if.sv
// Bundle of the slow-tick, switch and display signals exchanged between the
// input conditioning, the zone controller and the matrix display decoders.
interface irrigation_zone_controller_if #(
  parameter int ZONES       = 4,
  parameter int LEVEL_WIDTH = 3
);
  logic                         tick;
  logic [ZONES-1:0]             splinker_switch;
  logic [ZONES-1:0]             dripper_switch;
  logic [ZONES-1:0]             fertilise_request;
  logic [ZONES*LEVEL_WIDTH-1:0] water_level;
  logic [ZONES-1:0]             splinker;
  logic [ZONES-1:0]             dripper;
  logic [ZONES-1:0]             filling;
  logic [ZONES-1:0]             fertilising;
  logic [ZONES-1:0]             input_error;
  logic                         alarm;

  modport master (
    output tick, splinker_switch, dripper_switch, fertilise_request,
    input  water_level, splinker, dripper, filling, fertilising, input_error, alarm
  );

  modport slave (
    input  tick, splinker_switch, dripper_switch, fertilise_request,
    output water_level, splinker, dripper, filling, fertilising, input_error, alarm
  );
endinterface

// File: rtl/irrigation_zone_controller.sv
// Multi-zone irrigation controller: per-zone tank level and watering FSM,
// one shared fill pump granted round-robin, fertiliser injection during fill.
module irrigation_zone_controller #(
  parameter int ZONES          = 4,
  parameter int LEVEL_WIDTH    = 3,
  parameter int CRITICAL_LEVEL = 1,
  parameter int SPRINKLE_TICKS = 1,
  parameter int DRIP_TICKS     = 3,
  parameter int FILL_TICKS     = 2
) (
  input logic                         clock,
  input logic                         reset_button,
  irrigation_zone_controller_if.slave bus
);
  localparam int MAX_TICKS_A = (SPRINKLE_TICKS > DRIP_TICKS) ? SPRINKLE_TICKS : DRIP_TICKS;
  localparam int MAX_TICKS   = (MAX_TICKS_A > FILL_TICKS) ? MAX_TICKS_A : FILL_TICKS;
  localparam int SUB_W       = (MAX_TICKS > 1) ? $clog2(MAX_TICKS) : 1;
  localparam int PTR_W       = $clog2(ZONES);

  localparam logic [LEVEL_WIDTH-1:0] MAX_L     = '1;
  localparam logic [LEVEL_WIDTH-1:0] CRIT_L    = LEVEL_WIDTH'(CRITICAL_LEVEL);
  localparam logic [SUB_W-1:0]       SPR_LAST  = SUB_W'(SPRINKLE_TICKS - 1);
  localparam logic [SUB_W-1:0]       DRIP_LAST = SUB_W'(DRIP_TICKS - 1);
  localparam logic [SUB_W-1:0]       FILL_LAST = SUB_W'(FILL_TICKS - 1);
  localparam logic [PTR_W-1:0]       LAST_PTR  = PTR_W'(ZONES - 1);

  typedef enum logic [2:0] {
    IDLE,
    WATER,
    WAIT_PUMP,
    FILL,
    ERROR
  } state_t;

  state_t                 state_q [ZONES];
  state_t                 state_d [ZONES];
  logic [LEVEL_WIDTH-1:0] level_q [ZONES];
  logic [LEVEL_WIDTH-1:0] level_d [ZONES];
  logic [SUB_W-1:0]       sub_q   [ZONES];
  logic [SUB_W-1:0]       sub_d   [ZONES];

  logic [ZONES-1:0] mode_q;
  logic [ZONES-1:0] fert_q;
  logic [ZONES-1:0] fert_d;
  logic [ZONES-1:0] in_fill;
  logic [ZONES-1:0] both_on;
  logic [ZONES-1:0] one_on;
  logic [ZONES-1:0] grant;
  logic [PTR_W-1:0] ptr_q;
  logic [PTR_W-1:0] ptr_d;
  logic [PTR_W-1:0] grant_idx;
  logic             grant_valid;
  logic             pump_busy;
  logic             alarm_q;
  logic             alarm_d;

  assign both_on = bus.splinker_switch & bus.dripper_switch;
  assign one_on  = bus.splinker_switch ^ bus.dripper_switch;

  always_comb begin
    in_fill = '0;
    for (int unsigned z = 0; z < ZONES; z++) begin
      in_fill[z] = (state_q[z] == FILL);
    end
  end

  // Round-robin search starting at the pointer; only while the pump is free.
  always_comb begin
    pump_busy   = |in_fill;
    grant       = '0;
    grant_idx   = '0;
    grant_valid = 1'b0;
    if (!pump_busy) begin
      for (int unsigned i = 0; i < ZONES; i++) begin
        if (!grant_valid && state_q[(32'(ptr_q) + i) % ZONES] == WAIT_PUMP) begin
          grant_valid = 1'b1;
          grant_idx   = PTR_W'((32'(ptr_q) + i) % ZONES);
          grant[(32'(ptr_q) + i) % ZONES] = 1'b1;
        end
      end
    end
    ptr_d = ptr_q;
    if (grant_valid) begin
      ptr_d = (grant_idx == LAST_PTR) ? '0 : grant_idx + PTR_W'(1);
    end
  end

  always_comb begin
    for (int unsigned z = 0; z < ZONES; z++) begin
      state_d[z] = state_q[z];
      level_d[z] = level_q[z];
      sub_d[z]   = sub_q[z];
      case (state_q[z])
        IDLE: begin
          if (both_on[z])                state_d[z] = ERROR;
          else if (level_q[z] <= CRIT_L) state_d[z] = WAIT_PUMP;
          else if (one_on[z])            state_d[z] = WATER;
        end
        WATER: begin
          if (both_on[z])                state_d[z] = ERROR;
          else if (!one_on[z])           state_d[z] = IDLE;
          else if (level_q[z] <= CRIT_L) state_d[z] = WAIT_PUMP;
          else if (bus.dripper_switch[z] != mode_q[z]) sub_d[z] = '0;
          else if (bus.tick) begin
            if (sub_q[z] == (bus.dripper_switch[z] ? DRIP_LAST : SPR_LAST)) begin
              sub_d[z]   = '0;
              level_d[z] = level_q[z] - LEVEL_WIDTH'(1);
            end else begin
              sub_d[z] = sub_q[z] + SUB_W'(1);
            end
          end
        end
        WAIT_PUMP: begin
          if (grant[z]) state_d[z] = FILL;
        end
        FILL: begin
          // Increment only happens below MAX_L, so the level cannot wrap.
          if (level_q[z] == MAX_L) state_d[z] = IDLE;
          else if (bus.tick) begin
            if (sub_q[z] == FILL_LAST) begin
              sub_d[z]   = '0;
              level_d[z] = level_q[z] + LEVEL_WIDTH'(1);
            end else begin
              sub_d[z] = sub_q[z] + SUB_W'(1);
            end
          end
        end
        ERROR: begin
          if (!both_on[z]) state_d[z] = IDLE;
        end
        default: state_d[z] = IDLE;
      endcase
      if (state_d[z] != state_q[z]) sub_d[z] = '0;
    end
  end

  always_comb begin
    fert_d = '0;
    for (int unsigned z = 0; z < ZONES; z++) begin
      fert_d[z] = (state_d[z] == FILL) &&
                  (fert_q[z] || (in_fill[z] && bus.fertilise_request[z]));
    end
    alarm_d = |(bus.fertilise_request & ~in_fill);
  end

  always_ff @(posedge clock or negedge reset_button) begin
    if (!reset_button) begin
      for (int unsigned z = 0; z < ZONES; z++) begin
        state_q[z] <= IDLE;
        level_q[z] <= MAX_L;
        sub_q[z]   <= '0;
      end
      mode_q  <= '0;
      fert_q  <= '0;
      ptr_q   <= '0;
      alarm_q <= 1'b0;
    end else begin
      for (int unsigned z = 0; z < ZONES; z++) begin
        state_q[z] <= state_d[z];
        level_q[z] <= level_d[z];
        sub_q[z]   <= sub_d[z];
      end
      mode_q  <= bus.dripper_switch;
      fert_q  <= fert_d;
      ptr_q   <= ptr_d;
      alarm_q <= alarm_d;
    end
  end

  // Valves are gated by the same conditions that keep the zone in WATER.
  always_comb begin
    bus.splinker    = '0;
    bus.dripper     = '0;
    bus.filling     = '0;
    bus.water_level = '0;
    for (int unsigned z = 0; z < ZONES; z++) begin
      bus.splinker[z] = (state_q[z] == WATER) && one_on[z] && (level_q[z] > CRIT_L) &&
                        bus.splinker_switch[z];
      bus.dripper[z]  = (state_q[z] == WATER) && one_on[z] && (level_q[z] > CRIT_L) &&
                        bus.dripper_switch[z];
      bus.filling[z]  = in_fill[z];
      bus.water_level[z*LEVEL_WIDTH +: LEVEL_WIDTH] = level_q[z];
    end
  end

  assign bus.fertilising = fert_q;
  assign bus.input_error = both_on;
  assign bus.alarm       = alarm_q;
endmodule

// File: tb/tb_irrigation_zone_controller.sv
// Directed bench for the four-zone irrigation controller with default timing
// parameters (MAX=7, CRIT=1, sprinkle 1, drip 3, fill 2 ticks).
module tb_irrigation_zone_controller;
  localparam int ZONES = 4;
  localparam int LW    = 3;

  logic clk = 1'b0;
  logic rst_n;
  int   errors = 0;
  int   checks = 0;

  irrigation_zone_controller_if #(.ZONES(ZONES), .LEVEL_WIDTH(LW)) bus ();

  irrigation_zone_controller #(
    .ZONES(ZONES),
    .LEVEL_WIDTH(LW),
    .CRITICAL_LEVEL(1),
    .SPRINKLE_TICKS(1),
    .DRIP_TICKS(3),
    .FILL_TICKS(2)
  ) dut (
    .clock(clk),
    .reset_button(rst_n),
    .bus(bus.slave)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] lvl(input int z);
    return 32'(bus.water_level[z*LW +: LW]);
  endfunction

  task automatic clk_n(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse_tick();
    bus.tick = 1'b1;
    clk_n(1);
    bus.tick = 1'b0;
  endtask

  // Zone z is already in FILL at level `start`; run it up to 7 and out of FILL.
  task automatic fill_zone(input int z, input int start, input logic [3:0] fert);
    for (int p = 1; p <= 2 * (7 - start); p++) begin
      pulse_tick();
      check($sformatf("fill%0d_onehot", z), 32'(bus.filling), 32'(1 << z));
      check($sformatf("fill%0d_level", z), lvl(z), 32'(start + p / 2));
      check($sformatf("fill%0d_fert", z), 32'(bus.fertilising), 32'(fert));
    end
    clk_n(1);
    check($sformatf("fill%0d_release", z), 32'(bus.filling), 32'h0);
    check($sformatf("fill%0d_fert_clr", z), 32'(bus.fertilising), 32'h0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    clk_n(2);
    rst_n = 1'b1;
    clk_n(1);
  endtask

  initial begin
    rst_n                 = 1'b0;
    bus.tick              = 1'b0;
    bus.splinker_switch   = '0;
    bus.dripper_switch    = '0;
    bus.fertilise_request = '0;
    clk_n(2);
    check("rst_level", 32'(bus.water_level), 32'hFFF);
    check("rst_filling", 32'(bus.filling), 32'h0);
    check("rst_valves", 32'({bus.splinker, bus.dripper}), 32'h0);
    check("rst_alarm", 32'(bus.alarm), 32'h0);
    rst_n = 1'b1;
    clk_n(1);

    // Sprinkle zone 0 down to critical, then refill.
    bus.splinker_switch = 4'b0001;
    clk_n(1);
    check("t1_splinker_on", 32'(bus.splinker), 32'h1);
    for (int k = 1; k <= 6; k++) begin
      pulse_tick();
      check("t1_level0", lvl(0), 32'(7 - k));
    end
    check("t1_valve_off_at_crit", 32'(bus.splinker), 32'h0);
    clk_n(1);
    check("t1_wait_no_fill", 32'(bus.filling), 32'h0);
    bus.splinker_switch = '0;
    clk_n(1);
    check("t1_granted", 32'(bus.filling), 32'h1);
    fill_zone(0, 1, 4'b0000);

    // Drip zone 1 for 9 ticks, then hold.
    bus.dripper_switch = 4'b0010;
    clk_n(1);
    check("t2_dripper_on", 32'(bus.dripper), 32'h2);
    for (int k = 1; k <= 9; k++) pulse_tick();
    check("t2_level1", lvl(1), 32'd4);
    check("t2_level0", lvl(0), 32'd7);
    bus.dripper_switch = '0;
    clk_n(1);
    for (int k = 1; k <= 5; k++) pulse_tick();
    check("t2_hold", lvl(1), 32'd4);
    check("t2_dripper_off", 32'(bus.dripper), 32'h0);

    // Zones 0, 2, 3 critical together from a fresh pointer.
    do_reset();
    bus.splinker_switch = 4'b1101;
    clk_n(1);
    for (int k = 1; k <= 6; k++) pulse_tick();
    check("t3_levels", 32'(bus.water_level), 32'b001_001_111_001);
    clk_n(1);
    check("t3_wait", 32'(bus.filling), 32'h0);
    bus.splinker_switch = '0;
    clk_n(1);
    check("t3_first", 32'(bus.filling), 32'h1);
    fill_zone(0, 1, 4'b0000);
    clk_n(1);
    check("t3_second", 32'(bus.filling), 32'h4);
    fill_zone(2, 1, 4'b0000);
    clk_n(1);
    check("t3_third", 32'(bus.filling), 32'h8);
    fill_zone(3, 1, 4'b0000);
    clk_n(1);
    check("t3_done", 32'(bus.filling), 32'h0);

    // Input error while watering zone 2.
    bus.dripper_switch = 4'b0100;
    clk_n(1);
    check("t4_drip", 32'(bus.dripper), 32'h4);
    for (int k = 1; k <= 3; k++) pulse_tick();
    check("t4_level", lvl(2), 32'd6);
    bus.splinker_switch = 4'b0100;
    #1;
    check("t4_input_error", 32'(bus.input_error), 32'h4);
    check("t4_valves_off", 32'({bus.splinker, bus.dripper}), 32'h0);
    clk_n(1);
    for (int k = 1; k <= 3; k++) pulse_tick();
    check("t4_frozen", lvl(2), 32'd6);
    check("t4_err_valves", 32'({bus.splinker, bus.dripper}), 32'h0);
    bus.dripper_switch = '0;
    #1;
    check("t4_error_clear", 32'(bus.input_error), 32'h0);
    clk_n(1);
    check("t4_idle", 32'(bus.splinker), 32'h0);
    clk_n(1);
    check("t4_resume", 32'(bus.splinker), 32'h4);
    pulse_tick();
    check("t4_level_after", lvl(2), 32'd5);
    bus.splinker_switch = '0;
    clk_n(1);

    // Fertilise during fill, then invalid requests.
    bus.splinker_switch = 4'b0001;
    clk_n(1);
    for (int k = 1; k <= 6; k++) pulse_tick();
    check("t5_crit", lvl(0), 32'd1);
    clk_n(1);
    bus.splinker_switch = '0;
    clk_n(1);
    check("t5_fill", 32'(bus.filling), 32'h1);
    bus.fertilise_request = 4'b0001;
    clk_n(1);
    bus.fertilise_request = '0;
    check("t5_fert_on", 32'(bus.fertilising), 32'h1);
    check("t5_no_alarm", 32'(bus.alarm), 32'h0);
    bus.fertilise_request = 4'b0001;
    clk_n(1);
    bus.fertilise_request = '0;
    check("t5_repeat", 32'(bus.fertilising), 32'h1);
    check("t5_repeat_alarm", 32'(bus.alarm), 32'h0);
    fill_zone(0, 1, 4'b0001);
    check("t5_alarm_quiet", 32'(bus.alarm), 32'h0);
    bus.fertilise_request = 4'b0010;
    clk_n(1);
    bus.fertilise_request = '0;
    check("t5_alarm_pulse", 32'(bus.alarm), 32'h1);
    check("t5_fert1_off", 32'(bus.fertilising), 32'h0);
    clk_n(1);
    check("t5_alarm_end", 32'(bus.alarm), 32'h0);
    bus.fertilise_request = 4'b0110;
    clk_n(1);
    bus.fertilise_request = '0;
    check("t5_multi_alarm", 32'(bus.alarm), 32'h1);
    clk_n(1);
    check("t5_multi_end", 32'(bus.alarm), 32'h0);

    // Asynchronous reset mid-fill with another zone dripping.
    bus.dripper_switch  = 4'b0010;
    bus.splinker_switch = 4'b1000;
    clk_n(1);
    for (int k = 1; k <= 6; k++) pulse_tick();
    clk_n(1);
    bus.splinker_switch = '0;
    clk_n(1);
    check("t6_filling", 32'(bus.filling), 32'h8);
    check("t6_dripping", 32'(bus.dripper), 32'h2);
    for (int k = 1; k <= 3; k++) pulse_tick();
    #3;
    rst_n = 1'b0;
    #1;
    check("t6_abort_fill", 32'(bus.filling), 32'h0);
    check("t6_abort_valves", 32'({bus.splinker, bus.dripper}), 32'h0);
    check("t6_levels", 32'(bus.water_level), 32'hFFF);
    check("t6_fert", 32'(bus.fertilising), 32'h0);
    bus.dripper_switch = '0;
    #2;
    rst_n = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      pulse_tick();
      check("t6_no_grant", 32'(bus.filling), 32'h0);
    end
    check("t6_levels_hold", 32'(bus.water_level), 32'hFFF);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/irrigation_zone_controller.md
Name: irrigation_zone_controller

Overview:
- Parametrised multi-zone successor of the single-tank irrigation top level: ZONES independent zones, each with its own tank-level counter, sprinkler/dripper watering FSM and input-error check.
- All zones share one fill pump, granted round-robin.
- Per-zone fertilising during fill; global alarm on an invalid fertilise request.
- Sits between the switch/button conditioning and the matrix display decoders; consumes the slow-clock tick from the clock definer.

Parameters:
- ZONES, 4, number of irrigation zones (2..8).
- LEVEL_WIDTH, 3, tank level counter width; MAX_LEVEL = 2^LEVEL_WIDTH-1.
- CRITICAL_LEVEL, 1, level at or below which a watering zone requests the pump.
- SPRINKLE_TICKS, 1, ticks per level decrement while sprinkling.
- DRIP_TICKS, 3, ticks per level decrement while dripping.
- FILL_TICKS, 2, ticks per level increment while filling.

Ports:
- clock  in  1  system clock (fast clock domain).
- reset_button  in  1  asynchronous, active-low reset.
- tick  in  1  one-cycle enable pulse per slow-clock period.
- splinker_switch  in  ZONES  per-zone sprinkler request.
- dripper_switch  in  ZONES  per-zone dripper request.
- fertilise_request  in  ZONES  per-zone one-cycle fertilise pulse (already debounced and inverted).
- water_level  out  ZONES*LEVEL_WIDTH  per-zone level; zone z at bits [z*LEVEL_WIDTH +: LEVEL_WIDTH].
- splinker  out  ZONES  sprinkler valve on.
- dripper  out  ZONES  dripper valve on.
- filling  out  ZONES  pump routed to zone; at most one bit set.
- fertilising  out  ZONES  fertiliser injector on.
- input_error  out  ZONES  both switches on for the zone (combinational from inputs).
- alarm  out  1  one-cycle pulse on an invalid fertilise request.

Behaviour:
- Reset (reset_button=0, asynchronous):
  - every zone goes to IDLE with level = MAX_LEVEL and sub-tick counter = 0;
  - round-robin pointer = 0;
  - all outputs 0, except water_level = MAX_LEVEL per zone and input_error, which follows the inputs.
  - Reset mid-fill or mid-watering aborts immediately; no residual grant.
- Per-zone FSM. States are IDLE, WATER, WAIT_PUMP, FILL and ERROR. Transitions are evaluated every clock; level changes only on cycles with tick=1.
  - IDLE -> ERROR if both switches are on.
  - IDLE -> WATER if exactly one switch is on and level > CRITICAL_LEVEL.
  - IDLE -> WAIT_PUMP if level <= CRITICAL_LEVEL.
  - WATER:
    - splinker = splinker_switch, dripper = dripper_switch;
    - on tick, sub counter increments; when it reaches (mode TICKS - 1) it clears and level decrements by 1;
    - both switches on -> ERROR; both off -> IDLE (level held);
    - level <= CRITICAL_LEVEL -> WAIT_PUMP, with valves off in the same cycle the state changes.
  - A mode change (sprinkler <-> dripper) within WATER clears the sub counter.
  - ERROR: all valves off, level held. Exit to IDLE when the error clears.
  - WAIT_PUMP: no valves on. Waits for a grant; switches are ignored.
  - FILL:
    - filling[z] = 1; on tick, sub counter advances; every FILL_TICKS ticks level increments by 1;
    - at MAX_LEVEL -> IDLE, with filling dropping the same edge;
    - switches and error are ignored;
    - the level saturates at MAX_LEVEL and never wraps.
  - Entering any state clears the sub counter.
- Pump arbiter:
  - In a cycle where no zone is in FILL, the first zone in WAIT_PUMP searching upward from the pointer (wrapping) is granted. It enters FILL on the next edge.
  - The pointer becomes (granted+1) mod ZONES.
  - Simultaneous WAIT_PUMP entries are served strictly round-robin.
  - A zone leaving FILL frees the pump. A new grant is evaluated on the following cycle, so there is one idle cycle between fills.
- Fertilising:
  - fertilise_request[z] while zone z is in FILL latches fertilising[z] = 1 until the zone leaves FILL. A repeat request is ignored.
  - fertilise_request[z] in any other state produces alarm = 1 for exactly one cycle, and fertilising stays 0.
  - Multiple invalid requests in one cycle produce a single alarm pulse.
- Width rules: all level arithmetic is LEVEL_WIDTH unsigned. Sub counters are sized to hold max(SPRINKLE_TICKS, DRIP_TICKS, FILL_TICKS)-1.

Test Plan:
1. Reset, then zone0 splinker=1, 6 ticks (MAX=7, CRIT=1) -> level0 steps 7,6,5,4,3,2,1 one per tick. After reaching 1: splinker[0]=0, WAIT_PUMP, then filling=0001; level rises 1 per 2 ticks back to 7; filling returns to 0.
2. Zone1 dripper=1, 9 ticks -> level1 = 4. Drop dripper -> IDLE; level holds at 4 across 5 further ticks.
3. Zones 0,2,3 reach critical in the same cycle with pointer=0 -> fill order 0, then 2, then 3. filling is never multi-hot; one idle cycle between grants; pointer ends at 0.
4. Zone2 both switches on while in WATER -> input_error[2]=1, valves off, level frozen. Release dripper -> IDLE, then WATER with splinker on.
5. fertilise_request[0] during FILL -> fertilising[0]=1 until level=7, then 0, no alarm. fertilise_request[1] while zone1 is in IDLE -> alarm high for exactly 1 cycle, fertilising[1]=0.
6. Assert reset_button=0 mid-fill, asynchronously between clock edges -> filling, splinker and dripper go to 0 immediately; all levels = 7. After release, no zone is granted until one goes critical again.
